// File: rtl/session_arbiter_pkg.sv
// Shared types and default sizing for the per-slave session arbiter.
package session_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_N_MASTERS    = 4;
  localparam int unsigned DEF_MAX_BURST    = 4;
  localparam int unsigned DEF_RESP_TIMEOUT = 64;

endpackage

// File: rtl/session_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr, skipping excluded masters.
module rr_pick
  import session_arbiter_pkg::*;
#(
  parameter int unsigned N  = DEF_N_MASTERS,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          any_valid
);

  int unsigned   pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    pos        = 0;
    pos_idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos     = (32'(ptr) + i) % N;
      pos_idx = IW'(pos);
      if (!any_valid && req[pos_idx] && !excl[pos_idx]) begin
        any_valid       = 1'b1;
        winner[pos_idx] = 1'b1;
        winner_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/session_arbiter.sv
// Per-slave session scheduler: round-robin grant held for a whole session, bounded bursts, response timeout.
module session_arbiter
  import session_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS    = DEF_N_MASTERS,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req,
  input  logic [N_MASTERS-1:0]         cmd,
  input  logic                         slave_ack,
  input  logic                         slave_resp,
  output logic [N_MASTERS-1:0]         grant,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx,
  output logic                         session_done,
  output logic                         timeout_err
);

  localparam int unsigned IW = $clog2(N_MASTERS);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(RESP_TIMEOUT);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [BW-1:0]   burst_cnt;
  logic [TW-1:0]   tcnt;

  logic [IW-1:0]        ptr_next_c;
  logic [IW-1:0]        pick_ptr_c;
  logic [N_MASTERS-1:0] pick_excl_c;
  logic [N_MASTERS-1:0] win_c;
  logic [IW-1:0]        win_idx_c;
  logic                 any_valid_c;
  logic                 others_c;
  logic                 burst_ok_c;
  logic                 complete_c;
  logic                 to_resp_c;
  logic                 abort_c;
  logic                 timeout_c;
  logic                 keep_c;
  logic                 release_c;

  // Idle arbitration starts at ptr; a release re-arbitrates from the rotated pointer without the leaver.
  always_comb begin
    ptr_next_c  = IW'((32'(grant_idx) + 1) % N_MASTERS);
    pick_ptr_c  = (state == IDLE) ? ptr : ptr_next_c;
    pick_excl_c = (state == IDLE) ? '0 : grant;
    others_c    = |(req & ~grant);
    burst_ok_c  = (32'(burst_cnt) + 1) < MAX_BURST;
  end

  rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req        (req),
    .ptr        (pick_ptr_c),
    .excl       (pick_excl_c),
    .winner     (win_c),
    .winner_idx (win_idx_c),
    .any_valid  (any_valid_c)
  );

  // Session events; completion outranks abort and timeout.
  always_comb begin
    complete_c = 1'b0;
    to_resp_c  = 1'b0;
    abort_c    = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      ADDR: begin
        if (slave_ack) begin
          if (cmd[grant_idx]) complete_c = 1'b1;
          else                to_resp_c  = 1'b1;
        end else if (!req[grant_idx]) begin
          abort_c = 1'b1;
        end
      end
      RESP: begin
        if (slave_resp)                            complete_c = 1'b1;
        else if (tcnt == TW'(RESP_TIMEOUT - 1))    timeout_c  = 1'b1;
      end
      default: ;
    endcase
    keep_c    = complete_c && req[grant_idx] && (burst_ok_c || !others_c);
    release_c = (complete_c && !keep_c) || timeout_c || abort_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      grant_idx    <= '0;
      session_done <= 1'b0;
      timeout_err  <= 1'b0;
      ptr          <= '0;
      burst_cnt    <= '0;
      tcnt         <= '0;
    end else begin
      session_done <= complete_c;
      timeout_err  <= timeout_c;
      case (state)
        IDLE: begin
          if (any_valid_c) begin
            grant     <= win_c;
            grant_idx <= win_idx_c;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (to_resp_c) begin
            state <= RESP;
            tcnt  <= '0;
          end
        end
        RESP: begin
          if (!slave_resp && !timeout_c) tcnt <= tcnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
      if (keep_c) begin
        state <= ADDR;
        if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + BW'(1);
      end
      if (release_c) begin
        ptr       <= ptr_next_c;
        burst_cnt <= '0;
        if (any_valid_c) begin
          grant     <= win_c;
          grant_idx <= win_idx_c;
          state     <= ADDR;
        end else begin
          grant <= '0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_session_arbiter.sv
// Directed and randomized checks of session_arbiter against a session-level reference model.
module tb_session_arbiter;

  localparam int NM = 4;
  localparam int MB = 3;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] req;
  logic [NM-1:0] cmd;
  logic          slave_ack;
  logic          slave_resp;
  logic [NM-1:0] grant;
  logic [1:0]    grant_idx;
  logic          session_done;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the slave, whether it awaits read data, and the fairness bookkeeping.
  int m_owner   = -1;
  bit m_reading = 1'b0;
  int m_wait    = 0;
  int m_burst   = 0;
  int m_ptr     = 0;
  bit m_done    = 1'b0;
  bit m_to      = 1'b0;

  always #5 clk = ~clk;

  session_arbiter #(.N_MASTERS(NM), .MAX_BURST(MB), .RESP_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .cmd          (cmd),
    .slave_ack    (slave_ack),
    .slave_resp   (slave_resp),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .session_done (session_done),
    .timeout_err  (timeout_err)
  );

  function automatic int pick(input logic [NM-1:0] rq, input int start, input int skip);
    for (int i = 0; i < NM; i++) begin
      int c;
      c = (start + i) % NM;
      if (c != skip && rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic model(input logic [NM-1:0] rq, input logic [NM-1:0] cm,
                       input logic ak, input logic rs, input logic r);
    bit finish;
    bit leave;
    int prev;
    finish = 1'b0;
    leave  = 1'b0;
    m_done = 1'b0;
    m_to   = 1'b0;
    if (r) begin
      m_owner = -1; m_reading = 1'b0; m_ptr = 0; m_burst = 0;
      return;
    end
    if (m_owner < 0) begin
      m_owner   = pick(rq, m_ptr, -1);
      m_reading = 1'b0;
      return;
    end
    if (!m_reading) begin
      if (ak) begin
        if (cm[m_owner]) finish = 1'b1;
        else begin m_reading = 1'b1; m_wait = 0; end
      end else if (!rq[m_owner]) leave = 1'b1;
    end else begin
      if (rs) finish = 1'b1;
      else if (m_wait == TO - 1) begin m_to = 1'b1; leave = 1'b1; end
      else m_wait++;
    end
    if (finish) begin
      logic [NM-1:0] others;
      others  = rq;
      others[m_owner] = 1'b0;
      m_done  = 1'b1;
      m_burst++;
      if (rq[m_owner] && (m_burst < MB || others == '0)) m_reading = 1'b0;
      else leave = 1'b1;
    end
    if (leave) begin
      prev      = m_owner;
      m_ptr     = (prev + 1) % NM;
      m_burst   = 0;
      m_reading = 1'b0;
      m_owner   = pick(rq, m_ptr, prev);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [NM-1:0] rq, input logic [NM-1:0] cm,
                      input logic ak, input logic rs, input logic r, input string tag);
    logic [31:0] exp_grant;
    req = rq; cmd = cm; slave_ack = ak; slave_resp = rs; rst = r;
    model(rq, cm, ak, rs, r);
    @(posedge clk);
    #1;
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check({tag, ":grant"}, 32'(grant), exp_grant);
    if (m_owner >= 0) check({tag, ":grant_idx"}, 32'(grant_idx), 32'(m_owner));
    check({tag, ":session_done"}, 32'(session_done), 32'(m_done));
    check({tag, ":timeout_err"}, 32'(timeout_err), 32'(m_to));
  endtask

  initial begin
    rst = 1'b1; req = '0; cmd = '0; slave_ack = 1'b0; slave_resp = 1'b0;

    step(4'b0000, 4'b0000, 0, 0, 1, "reset");
    check("reset_idx", 32'(grant_idx), 32'd0);

    // Basic write on master 0
    step(4'b0001, 4'b0001, 0, 0, 0, "wr_grant");
    check("wr_grant_const", 32'(grant), 32'h1);
    step(4'b0000, 4'b0001, 1, 0, 0, "wr_ack");
    check("wr_done_const", 32'(session_done), 32'h1);
    step(4'b0000, 4'b0000, 0, 0, 0, "wr_idle");

    // Rotation under full load with immediate write acks
    step(4'b1111, 4'b1111, 0, 0, 0, "rot_start");
    for (int i = 0; i < 14; i++) step(4'b1111, 4'b1111, 1, 0, 0, "rot");
    step(4'b0000, 4'b0000, 0, 0, 1, "rot_rst");

    // Burst limit, then sole requester keeps the slave
    step(4'b0011, 4'b0011, 0, 0, 0, "burst_start");
    for (int i = 0; i < 6; i++) step(4'b0011, 4'b0011, 1, 0, 0, "burst");
    for (int i = 0; i < 8; i++) step(4'b0001, 4'b0011, 1, 0, 0, "solo");
    check("solo_const", 32'(grant), 32'h1);
    step(4'b0000, 4'b0000, 0, 0, 1, "burst_rst");

    // Read that times out, then a read answered on the last allowed cycle
    step(4'b0100, 4'b0000, 0, 0, 0, "to_grant");
    step(4'b0100, 4'b0000, 1, 0, 0, "to_ack");
    for (int i = 0; i < 7; i++) step(4'b0100, 4'b0000, 0, 0, 0, "to_wait");
    step(4'b0000, 4'b0000, 0, 0, 0, "to_fire");
    check("to_fire_const", 32'(timeout_err), 32'h1);
    step(4'b0100, 4'b0000, 0, 0, 0, "rd_grant");
    step(4'b0100, 4'b0000, 1, 0, 0, "rd_ack");
    for (int i = 0; i < 7; i++) step(4'b0100, 4'b0000, 0, 0, 0, "rd_wait");
    step(4'b0000, 4'b0000, 0, 1, 0, "rd_last");
    check("rd_last_const", 32'(session_done), 32'h1);

    // Abort, then reset during the response phase
    step(4'b0010, 4'b0010, 0, 0, 0, "ab_grant");
    step(4'b0000, 4'b0010, 0, 0, 0, "ab_drop");
    check("ab_drop_const", 32'(grant), 32'h0);
    step(4'b0100, 4'b0000, 0, 0, 0, "rr_grant");
    step(4'b0100, 4'b0000, 1, 0, 0, "rr_ack");
    step(4'b1111, 4'b0000, 0, 0, 1, "rr_rst");
    step(4'b1111, 4'b1111, 0, 0, 0, "rr_after");
    check("rr_after_const", 32'(grant), 32'h1);

    // Randomized traffic including occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 199) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
